crossing_comparator: RTL and testbench

Multi-channel, parametrised successor to the 20-bit registered comparator used by the waveform generator's output/threshold logic. Compares CH channel pairs (A vs B) in a valid-qualified 2-stage pipeline, with selectable compare mode and programmable hysteresis. Emits a level output, rise/fall pulses and a saturating crossing counter per channel. Feeds the trigger/sync logic and the DAC threshold-crossing status registers.

---
 rtl/comp_pkg.sv | 26 ++
 rtl/comp_channel.sv | 82 ++++++++
 rtl/crossing_comparator.sv | 83 ++++++++
 tb/tb_crossing_comparator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared mode encodings and operand extension helper
// for the multi-channel crossing comparator.
package comp_pkg;

   localparam logic [1:0] MODE_GT = 2'b00;
   localparam logic [1:0] MODE_GE = 2'b01;
   localparam logic [1:0] MODE_EQ = 2'b10;
   localparam logic [1:0] MODE_LT = 2'b11;

   localparam int EXT_MAX = 64;

   // Extend a w-bit value (held in the low bits of v) to EXT_MAX+1 bits.
   function automatic logic [EXT_MAX:0] ext_val(
      input logic [EXT_MAX-1:0] v,
      input int                 w,
      input logic               sgn
   );
      logic [EXT_MAX:0] r;
      r = {1'b0, v};
      for (int i = 0; i <= EXT_MAX; i++) begin
         if (i >= w) r[i] = sgn & v[w-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/comp_channel.sv
// One comparator channel: hysteresis next-state, edge
// pulses and the saturating rising-edge counter.
module comp_channel
   import comp_pkg::*;
#(
   parameter int W      = 20,
   parameter int CNT_W  = 16,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             v1,
   input  logic [1:0]       mode,
   input  logic             mode_chg,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [W-1:0]     hyst,
   input  logic             clear_cnt,
   output logic             comp_out,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] cnt
);

   // One bit beyond W+1 keeps A+H and B+H exact in both encodings.
   localparam int XW = W + 2;

   logic signed [XW-1:0] ax;
   logic signed [XW-1:0] bx;
   logic signed [XW-1:0] hx;
   logic signed [XW-1:0] ah;
   logic signed [XW-1:0] bh;
   logic                 s;
   logic                 nxt;

   assign ax = signed'(XW'(ext_val(
      {{(EXT_MAX-W){1'b0}}, a}, W, SIGNED != 0)));
   assign bx = signed'(XW'(ext_val(
      {{(EXT_MAX-W){1'b0}}, b}, W, SIGNED != 0)));
   assign hx = signed'({2'b00, hyst});
   assign ah = ax + hx;
   assign bh = bx + hx;

   // Release bounds are chosen so Hyst=0 collapses to the plain compare.
   always_comb begin
      s   = mode_chg ? 1'b0 : comp_out;
      nxt = s;
      unique case (1'b1)
         (mode == MODE_GT): nxt = s ? !(ah <= bx) : (ax > bx);
         (mode == MODE_GE): nxt = s ? !(ah < bx) : (ax >= bx);
         (mode == MODE_LT): nxt = s ? !(ax >= bh) : (ax < bx);
         (mode == MODE_EQ): nxt = (ax == bx);
         default:           nxt = s;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         comp_out <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
      end else if (v1) begin
         comp_out <= nxt;
         rise     <= !mode_chg & nxt & !comp_out;
         fall     <= !mode_chg & !nxt & comp_out;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear_cnt) begin
         cnt <= '0;
      end else if (rise && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/crossing_comparator.sv
// Multi-channel A/B crossing comparator: input register stage,
// valid pipeline and stored mode; per-channel logic in comp_channel.
module crossing_comparator
   import comp_pkg::*;
#(
   parameter int W      = 20,
   parameter int CH     = 4,
   parameter int CNT_W  = 16,
   parameter int SIGNED = 0
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                In_valid,
   input  logic [1:0]          Mode,
   input  logic [W-1:0]        Hyst,
   input  logic [CH*W-1:0]     Comp_A,
   input  logic [CH*W-1:0]     Comp_B,
   input  logic                Clear_cnt,
   output logic                Out_valid,
   output logic [CH-1:0]       Comp_out,
   output logic [CH-1:0]       Rise,
   output logic [CH-1:0]       Fall,
   output logic [CH*CNT_W-1:0] Cross_cnt
);

   logic [CH*W-1:0] a1;
   logic [CH*W-1:0] b1;
   logic [W-1:0]    h1;
   logic [1:0]      mode1;
   logic [1:0]      mode_q;
   logic            chg1;
   logic            v1;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         a1     <= '0;
         b1     <= '0;
         h1     <= '0;
         mode1  <= MODE_GT;
         mode_q <= MODE_GT;
         chg1   <= 1'b0;
         v1     <= 1'b0;
      end else begin
         v1 <= In_valid;
         if (In_valid) begin
            a1     <= Comp_A;
            b1     <= Comp_B;
            h1     <= Hyst;
            mode1  <= Mode;
            chg1   <= (Mode != mode_q);
            mode_q <= Mode;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) Out_valid <= 1'b0;
      else       Out_valid <= v1;
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      comp_channel #(
         .W      (W),
         .CNT_W  (CNT_W),
         .SIGNED (SIGNED)
      ) u_ch (
         .clk       (Clock),
         .rst       (Reset),
         .v1        (v1),
         .mode      (mode1),
         .mode_chg  (chg1),
         .a         (a1[i*W +: W]),
         .b         (b1[i*W +: W]),
         .hyst      (h1),
         .clear_cnt (Clear_cnt),
         .comp_out  (Comp_out[i]),
         .rise      (Rise[i]),
         .fall      (Fall[i]),
         .cnt       (Cross_cnt[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_crossing_comparator.sv
// Directed bench for crossing_comparator: vector table plus
// hand sequences for streaming, saturation, clear and reset.
module tb_crossing_comparator;

   localparam int W      = 20;
   localparam int CH     = 4;
   localparam int CNT_W  = 2;
   localparam int SIGNED = 1;

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic [1:0]          mode;
   logic [W-1:0]        hyst;
   logic [CH*W-1:0]     comp_a;
   logic [CH*W-1:0]     comp_b;
   logic                clear_cnt;
   logic                out_valid;
   logic [CH-1:0]       comp_out;
   logic [CH-1:0]       rise;
   logic [CH-1:0]       fall;
   logic [CH*CNT_W-1:0] cross_cnt;

   int passed;
   int total;

   typedef struct {
      logic [1:0]      mode;
      logic [W-1:0]    hyst;
      logic [CH*W-1:0] a;
      logic [CH*W-1:0] b;
      logic [CH-1:0]   comp;
      logic [CH-1:0]   rise;
      logic [CH-1:0]   fall;
      logic [7:0]      cnt;
   } vec_t;

   vec_t tv [14];

   crossing_comparator #(
      .W      (W),
      .CH     (CH),
      .CNT_W  (CNT_W),
      .SIGNED (SIGNED)
   ) dut (
      .Clock     (clk),
      .Reset     (rst),
      .In_valid  (in_valid),
      .Mode      (mode),
      .Hyst      (hyst),
      .Comp_A    (comp_a),
      .Comp_B    (comp_b),
      .Clear_cnt (clear_cnt),
      .Out_valid (out_valid),
      .Comp_out  (comp_out),
      .Rise      (rise),
      .Fall      (fall),
      .Cross_cnt (cross_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [CH*W-1:0] pk(
      input logic [W-1:0] x3, x2, x1, x0
   );
      return {x3, x2, x1, x0};
   endfunction

   task automatic chk(
      input string       nm,
      input logic [63:0] act,
      input logic [63:0] exp
   );
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h",
                    nm, act, exp);
   endtask

   task automatic drive(
      input logic [1:0]      m,
      input logic [W-1:0]    h,
      input logic [CH*W-1:0] a,
      input logic [CH*W-1:0] b
   );
      in_valid = 1'b1;
      mode     = m;
      hyst     = h;
      comp_a   = a;
      comp_b   = b;
   endtask

   logic [CH*W-1:0] b50;
   logic [CH*W-1:0] bm5;
   logic [CH*W-1:0] b3;
   logic [CH*W-1:0] all1;
   logic [CH*W-1:0] alle;
   logic            ev;

   initial begin
      passed    = 0;
      total     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      mode      = 2'b00;
      hyst      = '0;
      comp_a    = '0;
      comp_b    = '0;
      clear_cnt = 1'b0;

      b50  = pk(20'd50, 20'd50, 20'd50, 20'd50);
      bm5  = pk(20'hFFFFB, 20'hFFFFB, 20'hFFFFB, 20'hFFFFB);
      b3   = pk(20'd3, 20'd3, 20'd3, 20'd3);
      all1 = pk(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
      alle = pk(20'hFFFFE, 20'hFFFFE, 20'hFFFFE, 20'hFFFFE);

      tv[0]  = '{2'b00, 20'd0, pk(0, 0, 0, 100), b50,
                 4'h1, 4'h1, 4'h0, 8'h01};
      tv[1]  = '{2'b00, 20'd0, pk(0, 0, 0, 50), b50,
                 4'h0, 4'h0, 4'h1, 8'h01};
      tv[2]  = '{2'b00, 20'd10, pk(0, 0, 0, 60), b50,
                 4'h1, 4'h1, 4'h0, 8'h02};
      tv[3]  = '{2'b00, 20'd10, pk(0, 0, 0, 45), b50,
                 4'h1, 4'h0, 4'h0, 8'h02};
      tv[4]  = '{2'b00, 20'd10, pk(0, 0, 0, 39), b50,
                 4'h0, 4'h0, 4'h1, 8'h02};
      tv[5]  = '{2'b00, 20'd10, pk(0, 0, 0, 51), b50,
                 4'h1, 4'h1, 4'h0, 8'h03};
      tv[6]  = '{2'b11, 20'd2, pk(0, 0, 0, 20'hFFFFA), bm5,
                 4'h1, 4'h0, 4'h0, 8'h03};
      tv[7]  = '{2'b11, 20'd2, pk(0, 0, 0, 20'hFFFFC), bm5,
                 4'h1, 4'h0, 4'h0, 8'h03};
      tv[8]  = '{2'b11, 20'd2, pk(0, 0, 0, 20'hFFFFD), bm5,
                 4'h0, 4'h0, 4'h1, 8'h03};
      tv[9]  = '{2'b10, 20'd0, all1, all1,
                 4'hF, 4'h0, 4'h0, 8'h03};
      tv[10] = '{2'b10, 20'd0, alle, all1,
                 4'h0, 4'h0, 4'hF, 8'h03};
      tv[11] = '{2'b00, 20'd0, pk(0, 0, 7, 0), b3,
                 4'h2, 4'h0, 4'h0, 8'h03};
      tv[12] = '{2'b00, 20'd0, pk(0, 0, 2, 0), b3,
                 4'h0, 4'h0, 4'h2, 8'h03};
      tv[13] = '{2'b00, 20'd0, pk(0, 0, 7, 0), b3,
                 4'h2, 4'h2, 4'h0, 8'h07};

      // reset state
      @(negedge clk);
      chk("rst_ov", 64'(out_valid), 64'd0);
      chk("rst_comp", 64'(comp_out), 64'd0);
      chk("rst_rise", 64'(rise), 64'd0);
      chk("rst_fall", 64'(fall), 64'd0);
      chk("rst_cnt", 64'(cross_cnt), 64'd0);
      rst = 1'b0;

      // table
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(tv[i].mode, tv[i].hyst, tv[i].a, tv[i].b);
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("v%0d_lat", i), 64'(out_valid), 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d_ov", i), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d_comp", i), 64'(comp_out),
             64'(tv[i].comp));
         chk($sformatf("v%0d_rise", i), 64'(rise),
             64'(tv[i].rise));
         chk($sformatf("v%0d_fall", i), 64'(fall),
             64'(tv[i].fall));
         @(negedge clk);
         chk($sformatf("v%0d_ov0", i), 64'(out_valid), 64'd0);
         chk($sformatf("v%0d_pulse0", i),
             64'({rise, fall}), 64'd0);
         chk($sformatf("v%0d_hold", i), 64'(comp_out),
             64'(tv[i].comp));
         chk($sformatf("v%0d_cnt", i), 64'(cross_cnt),
             64'(tv[i].cnt));
      end

      // back-to-back stream, 5 rises on ch0 saturate the counter
      @(negedge clk);
      clear_cnt = 1'b1;
      @(negedge clk);
      clear_cnt = 1'b0;
      chk("clr_cnt", 64'(cross_cnt), 64'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            ev = ((i - 2) % 2 == 0);
            chk($sformatf("s%0d_ov", i - 2),
                64'(out_valid), 64'd1);
            chk($sformatf("s%0d_comp0", i - 2),
                64'(comp_out[0]), 64'(ev));
            chk($sformatf("s%0d_rise0", i - 2),
                64'(rise[0]), 64'(ev));
            chk($sformatf("s%0d_fall0", i - 2),
                64'(fall[0]), 64'(!ev));
         end
         if (i < 10) begin
            if (i % 2 == 0)
               drive(2'b00, 20'd0, pk(0, 0, 0, 100), b50);
            else
               drive(2'b00, 20'd0, pk(0, 0, 0, 0), b50);
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("sat_cnt0", 64'(cross_cnt[1:0]), 64'd3);
      chk("sat_ov", 64'(out_valid), 64'd0);

      // clear on the same cycle as a rise
      drive(2'b00, 20'd0, pk(0, 0, 0, 100), b50);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("cr_rise", 64'(rise[0]), 64'd1);
      chk("cr_pre", 64'(cross_cnt[1:0]), 64'd3);
      clear_cnt = 1'b1;
      @(negedge clk);
      clear_cnt = 1'b0;
      chk("cr_cnt", 64'(cross_cnt), 64'd0);
      @(negedge clk);
      chk("cr_cnt2", 64'(cross_cnt), 64'd0);

      // fall then rise to leave a nonzero count before reset
      drive(2'b00, 20'd0, pk(0, 0, 0, 0), b50);
      @(negedge clk);
      drive(2'b00, 20'd0, pk(0, 0, 0, 100), b50);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_cnt", 64'(cross_cnt), 64'd1);
      chk("pre_rst_comp", 64'(comp_out), 64'd1);

      // reset with a sample in flight
      drive(2'b00, 20'd0, pk(0, 0, 0, 0), b50);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_ov", 64'(out_valid), 64'd0);
      chk("mrst_comp", 64'(comp_out), 64'd0);
      chk("mrst_cnt", 64'(cross_cnt), 64'd0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_ov1", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("post_rst_ov2", 64'(out_valid), 64'd0);
      drive(2'b00, 20'd0, pk(0, 0, 0, 100), b50);
      @(negedge clk);
      in_valid = 1'b0;
      chk("post_lat1", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("post_lat2", 64'(out_valid), 64'd1);
      chk("post_comp", 64'(comp_out), 64'd1);
      chk("post_rise", 64'(rise), 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
